// File: rtl/round_and_pack_float.sv
// Round-and-pack stage: rounds a sign / biased exponent / unpacked significand
// into an IEEE-754 word of any width, behind an ap_start/ap_done handshake.
module round_and_pack_float #(
    parameter  int EXP_W  = 11,
    parameter  int FRAC_W = 52,
    parameter  int GRD_W  = 10,
    localparam int SIG_W  = FRAC_W + 2 + GRD_W,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic             zSign,
    input  logic [EXP_W:0]   zExp,
    input  logic [SIG_W-1:0] zSig,
    input  logic [1:0]       round_mode,
    input  logic [31:0]      float_exception_flag_i,
    output logic [31:0]      float_exception_flag_o,
    output logic             float_exception_flag_o_ap_vld,
    output logic [W-1:0]     ap_return
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, FINISH} state_t;

    localparam logic [EXP_W-1:0] EXP_OVF    = {{(EXP_W-2){1'b1}}, 2'b01};
    localparam logic [EXP_W:0]   SIG_W_E    = (EXP_W+1)'(SIG_W);
    localparam logic [GRD_W-1:0] ROUND_MAX  = {GRD_W{1'b1}};
    localparam logic [GRD_W-1:0] ROUND_HALF = {1'b1, {(GRD_W-1){1'b0}}};
    localparam logic [31:0]      FLAG_INEXACT   = 32'h1;
    localparam logic [31:0]      FLAG_UNDERFLOW = 32'h4;
    localparam logic [31:0]      FLAG_OVERFLOW  = 32'h8;

    function automatic logic [GRD_W-1:0] round_inc(input logic [1:0] mode, input logic sign);
        logic [GRD_W-1:0] inc;
        case (mode)
            2'd0:    inc = ROUND_HALF;
            2'd1:    inc = '0;
            2'd2:    inc = sign ? ROUND_MAX : '0;
            default: inc = sign ? '0 : ROUND_MAX;
        endcase
        return inc;
    endfunction

    // Carry out of the round bits when the increment is added to them.
    function automatic logic round_carry(input logic [GRD_W-1:0] rb, input logic [GRD_W-1:0] inc);
        return rb > (ROUND_MAX - inc);
    endfunction

    function automatic logic [W-1:0] pack(input logic sign, input logic [EXP_W-1:0] e,
                                          input logic [FRAC_W+1:0] s);
        return {sign, {(W-1){1'b0}}} + ({{(FRAC_W+1){1'b0}}, e} << FRAC_W)
             + {{(EXP_W-1){1'b0}}, s};
    endfunction

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [1:0]        mode_q, mode_d;
    logic [31:0]       flag_q, flag_d;
    logic [31:0]       raised_q, raised_d;
    logic              tiny_q, tiny_d;
    logic [W-1:0]      ret_q, ret_d;

    logic [GRD_W-1:0]  inc_in, inc_q, rb;
    logic              in_top, ovf_in;
    logic [EXP_W:0]    shift_cnt;
    logic [SIG_W-1:0]  jam;
    logic [FRAC_W+1:0] rnd_s;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        mode_d   = mode_q;
        flag_d   = flag_q;
        raised_d = raised_q;
        tiny_d   = tiny_q;
        ret_d    = ret_q;

        // Overflow test on the raw inputs: does rounding push the sum into bit SIG_W-1?
        inc_in = round_inc(round_mode, zSign);
        in_top = zSig[SIG_W-1] ^ (&zSig[SIG_W-2:GRD_W] & round_carry(zSig[GRD_W-1:0], inc_in));
        ovf_in = !zExp[EXP_W] && (zExp[EXP_W-1:0] >= EXP_OVF)
                 && ((zExp[EXP_W-1:0] > EXP_OVF) || in_top);

        shift_cnt = '0 - exp_q;
        if (shift_cnt >= SIG_W_E)
            jam = {{(SIG_W-1){1'b0}}, |sig_q};
        else
            jam = (sig_q >> shift_cnt)
                | {{(SIG_W-1){1'b0}}, |(sig_q & ~({SIG_W{1'b1}} << shift_cnt))};

        inc_q = round_inc(mode_q, sign_q);
        rb    = sig_q[GRD_W-1:0];
        rnd_s = sig_q[SIG_W-1:GRD_W] + {{(FRAC_W+1){1'b0}}, round_carry(rb, inc_q)};
        if (mode_q == 2'd0 && rb == ROUND_HALF)
            rnd_s[0] = 1'b0;

        case (state_q)
            IDLE: if (ap_start) begin
                sign_d   = zSign;
                exp_d    = zExp;
                sig_d    = zSig;
                mode_d   = round_mode;
                flag_d   = float_exception_flag_i;
                raised_d = '0;
                tiny_d   = 1'b0;
                if (ovf_in) begin
                    ret_d    = {zSign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                             - {{(W-1){1'b0}}, inc_in == '0};
                    raised_d = FLAG_OVERFLOW | FLAG_INEXACT;
                    state_d  = FINISH;
                end else if (zExp[EXP_W]) begin
                    state_d = SHIFT;
                end else begin
                    state_d = ROUND;
                end
            end
            SHIFT: begin
                sig_d   = jam;
                exp_d   = '0;
                tiny_d  = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                raised_d = ((rb != '0) ? FLAG_INEXACT : '0)
                         | ((rb != '0 && tiny_q) ? FLAG_UNDERFLOW : '0);
                ret_d    = pack(sign_q, (rnd_s == '0) ? '0 : exp_q[EXP_W-1:0], rnd_s);
                state_d  = FINISH;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            mode_q   <= '0;
            flag_q   <= '0;
            raised_q <= '0;
            tiny_q   <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            mode_q   <= mode_d;
            flag_q   <= flag_d;
            raised_q <= raised_d;
            tiny_q   <= tiny_d;
            ret_q    <= ret_d;
        end
    end

    assign ap_done   = (state_q == FINISH);
    assign ap_ready  = ap_done;
    assign ap_idle   = (state_q == IDLE) && !ap_start;
    assign ap_return = ret_q;
    assign float_exception_flag_o        = ap_done ? (flag_q | raised_q) : float_exception_flag_i;
    assign float_exception_flag_o_ap_vld = ap_done && (raised_q != '0);

endmodule
